// File: rtl/cond_flag_unit_if.sv
// Condition/flag unit bus: per-lane instruction inputs, stack controls, and the flag/stack status it returns.
// The master drives instructions and controls; the slave (the unit) returns the lane results and its state.
interface cond_flag_unit_if #(
    parameter int LANES = 2,
    parameter int DEPTH = 4
);
    logic [LANES-1:0]         valid;
    logic [4*LANES-1:0]       cond;
    logic [4*LANES-1:0]       flags_in;
    logic [2*LANES-1:0]       flag_write;
    logic                     stall;
    logic                     flush;
    logic                     save;
    logic                     restore;
    logic [LANES-1:0]         cond_ex;
    logic [LANES-1:0]         carry_in;
    logic [3:0]               flags_q;
    logic [$clog2(DEPTH):0]   depth;
    logic                     ovf_err;
    logic                     unf_err;

    modport master (
        output valid, cond, flags_in, flag_write, stall, flush, save, restore,
        input  cond_ex, carry_in, flags_q, depth, ovf_err, unf_err
    );

    modport slave (
        input  valid, cond, flags_in, flag_write, stall, flush, save, restore,
        output cond_ex, carry_in, flags_q, depth, ovf_err, unf_err
    );
endinterface

// File: rtl/cond_flag_unit.sv
// Multi-lane condition evaluator with same-cycle flag forwarding and a flag shadow stack.
// cond_ex/carry_in are combinational; flags, stack and errors update one edge later; stall freezes all state.
module cond_flag_unit #(
    parameter int LANES = 2,
    parameter int DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    cond_flag_unit_if.slave    bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int DW = AW + 1;

    logic [3:0]    flg_q, flg_d;
    logic [DW-1:0] dep_q, dep_d;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;
    logic [3:0]    stk_q [DEPTH];

    logic [LANES-1:0] cex, cin;
    logic [3:0]       lane_flg;
    logic             stk_we;
    logic [AW-1:0]    stk_wa;
    logic [AW-1:0]    top_idx;
    logic [3:0]       top_flg;
    logic             empty, full;

    // Flags are {C,V,N,Z}.
    function automatic logic cond_pass(input logic [3:0] code, input logic [3:0] f);
        logic c, v, n, z, p;
        {c, v, n, z} = f;
        case (code)
            4'd0:    p = z;
            4'd1:    p = !z;
            4'd2:    p = c;
            4'd3:    p = !c;
            4'd4:    p = n;
            4'd5:    p = !n;
            4'd6:    p = v;
            4'd7:    p = !v;
            4'd8:    p = c & !z;
            4'd9:    p = !c | z;
            4'd10:   p = (n == v);
            4'd11:   p = (n != v);
            4'd12:   p = !z & (n == v);
            4'd13:   p = z | (n != v);
            4'd14:   p = 1'b1;
            default: p = 1'b0;
        endcase
        return p;
    endfunction

    // Lanes are walked in program order so each sees the flags left by earlier committing lanes.
    always_comb begin
        lane_flg = flg_q;
        cex      = '0;
        cin      = '0;
        for (int i = 0; i < LANES; i++) begin
            cin[i] = lane_flg[3];
            cex[i] = bus.valid[i] & cond_pass(bus.cond[4*i +: 4], lane_flg);
            if (cex[i] && !bus.flush && !bus.stall) begin
                if (bus.flag_write[2*i+1]) lane_flg[3:2] = bus.flags_in[4*i+2 +: 2];
                if (bus.flag_write[2*i])   lane_flg[1:0] = bus.flags_in[4*i +: 2];
            end
        end
    end

    assign empty   = (dep_q == '0);
    assign full    = (dep_q == DW'(DEPTH));
    assign top_idx = dep_q[AW-1:0] - AW'(1);
    assign top_flg = stk_q[top_idx];

    always_comb begin
        flg_d  = flg_q;
        dep_d  = dep_q;
        ovf_d  = ovf_q;
        unf_d  = unf_q;
        stk_we = 1'b0;
        stk_wa = dep_q[AW-1:0];
        if (!bus.stall) begin
            flg_d = lane_flg;
            if (bus.save && bus.restore && !empty) begin
                // Swap: top takes the pre-commit flags, flags take the old top.
                stk_we = 1'b1;
                stk_wa = top_idx;
                flg_d  = top_flg;
            end else begin
                if (bus.restore) begin
                    if (empty) begin
                        unf_d = 1'b1;
                    end else begin
                        flg_d = top_flg;
                        dep_d = dep_q - DW'(1);
                    end
                end
                if (bus.save) begin
                    if (full) begin
                        ovf_d = 1'b1;
                    end else begin
                        stk_we = 1'b1;
                        stk_wa = dep_q[AW-1:0];
                        dep_d  = dep_q + DW'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flg_q <= 4'b0000;
            dep_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            flg_q <= flg_d;
            dep_q <= dep_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    // Stack storage needs no reset; depth alone defines which entries are live.
    always_ff @(posedge clk) begin
        if (stk_we && reset) stk_q[stk_wa] <= flg_q;
    end

    assign bus.cond_ex  = cex;
    assign bus.carry_in = cin;
    assign bus.flags_q  = flg_q;
    assign bus.depth    = dep_q;
    assign bus.ovf_err  = ovf_q;
    assign bus.unf_err  = unf_q;
endmodule

// File: doc/cond_flag_unit.md
COND_FLAG_UNIT -- requirements
Module: cond_flag_unit

Interface
REQ-001 SHALL have parameter LANES, default 2, number of instructions evaluated per cycle (1..4).
REQ-002 SHALL have parameter DEPTH, default 4, number of entries in the flag shadow stack (power of two, 2..16).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port valid  input  LANES  lane i holds a live instruction.
REQ-006 SHALL have port cond  input  4*LANES  condition field of lane i, bits [4i+3:4i].
REQ-007 SHALL have port flags_in  input  4*LANES  new flags of lane i, ordered {C,V,N,Z}, bits [4i+3:4i].
REQ-008 SHALL have port flag_write  input  2*LANES  lane i: bit [2i+1] writes C,V; bit [2i] writes N,Z.
REQ-009 SHALL have port stall  input  1  freeze all state this cycle.
REQ-010 SHALL have port flush  input  1  suppress all lane flag writes this cycle.
REQ-011 SHALL have port save  input  1  push current flags onto the shadow stack.
REQ-012 SHALL have port restore  input  1  pop the shadow stack into the flags register.
REQ-013 SHALL have port cond_ex  output  LANES  lane i condition passed.
REQ-014 SHALL have port carry_in  output  LANES  C flag as seen by lane i.
REQ-015 SHALL have port flags_q  output  4  architectural flags {C,V,N,Z}.
REQ-016 SHALL have port depth  output  $clog2(DEPTH)+1  occupied stack entries.
REQ-017 SHALL have ports ovf_err, unf_err  output  1 each  sticky stack overflow / underflow.

Function
REQ-018 SHALL decode cond as: 0 Z, 1 !Z, 2 C, 3 !C, 4 N, 5 !N, 6 V, 7 !V, 8 C&!Z, 9 !C|Z, 10 N==V, 11 N!=V, 12 !Z&(N==V), 13 Z|(N!=V), 14 always 1, 15 always 0.
REQ-019 SHALL evaluate lane 0 against flags_q, and lane i>0 against flags_q as updated by all committing lanes 0..i-1 in program order (combinational same-cycle forwarding).
REQ-020 SHALL make lane i commit its flags only when valid[i] & cond_ex[i] & !flush & !stall; C,V and N,Z groups update independently per flag_write.
REQ-021 SHALL drive cond_ex[i] = 0 and carry_in[i] = forwarded C whenever valid[i] = 0; invalid lanes never commit.
REQ-022 SHALL load flags_q on the clock edge with the value after the highest committing lane (later lanes override earlier per group).
REQ-023 SHALL on save (no stall) push flags_q as held before this cycle's lane commits; depth increments by 1.
REQ-024 SHALL on restore (no stall) load flags_q from the top entry, discarding all lane commits of that cycle; depth decrements by 1.
REQ-025 SHALL on save and restore together (no stall, depth>0) replace the top entry with pre-commit flags_q and load flags_q from the old top; depth unchanged.
REQ-026 SHALL on save with depth = DEPTH (and no restore) drop the push, set ovf_err, leave depth and flags unchanged except for lane commits.
REQ-027 SHALL on restore with depth = 0 ignore the pop, set unf_err, and apply lane commits normally.
REQ-028 SHALL when stall = 1 hold flags_q, stack, depth and errors; cond_ex and carry_in remain combinationally valid.
REQ-029 SHALL keep ovf_err and unf_err set until reset.

Reset
REQ-030 SHALL on reset low, asynchronously: flags_q = 4'b0000, depth = 0, ovf_err = 0, unf_err = 0; stack contents don't-care.
REQ-031 SHALL resume normal operation on the first rising clk edge after reset deasserts; an assertion mid-save/restore discards that operation.

Verification
REQ-032 SHALL cover: reset, lane0 cond=14 flags_in=4'b0001 flag_write=01 -> next flags_q=0001; lane1 cond=0 same cycle -> cond_ex[1]=1.
REQ-033 SHALL cover: flags_q=0000, lane0 cond=0 (fails) with flag_write=11 flags_in=1111 -> flags_q stays 0000, cond_ex=0.
REQ-034 SHALL cover: flags_q=1000, save, then lane writes 0001, then restore -> flags_q=1000, depth 0->1->0.
REQ-035 SHALL cover: DEPTH+1 saves -> depth=DEPTH, ovf_err=1; then restore at depth 0 (after DEPTH pops) -> unf_err=1, flags_q unchanged.
REQ-036 SHALL cover: stall=1 with lane0 committing flags_in=1111 and save -> flags_q, depth unchanged; flush=1 alone -> no flag update, save still pushes.
REQ-037 SHALL cover: reset asserted mid-cycle with depth=3, flags_q=1010 -> immediately flags_q=0000, depth=0, errors 0.
